// File: rtl/decode_fwd_scoreboard_pkg.sv
// Shared types and constants for the decode-stage operand/hazard unit.
//   regidx_t   : architectural register index
//   word_t     : operand / result word
//   fwd_src_t  : one forwarding source {valid, id, data}
//   LAT_*      : producer latencies used when issuing into the unit
package decode_fwd_scoreboard_pkg;

  localparam int unsigned NREG_DEF    = 32;
  localparam int unsigned NUM_FWD_DEF = 2;
  localparam int unsigned LAT_W_DEF   = 3;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned IDX_W_DEF   = $clog2(NREG_DEF);

  typedef logic [IDX_W_DEF-1:0]  regidx_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  typedef struct packed {
    logic    valid;
    regidx_t id;
    word_t   data;
  } fwd_src_t;

  localparam logic [LAT_W_DEF-1:0] LAT_ALU    = 3'd1;
  localparam logic [LAT_W_DEF-1:0] LAT_LOAD   = 3'd2;
  localparam logic [LAT_W_DEF-1:0] LAT_MULDIV = 3'd5;

endpackage

// File: rtl/decode_fwd_scoreboard_scoreboard.sv
// reg_scoreboard: per-register latency counters.
//   clk, resetn      : clock, asynchronous active-low reset
//   set_en/id/lat    : load cnt[set_id] with set_lat (ignored for r0)
//   rd_id1/rd_id2    : lookup indices
//   pend1/pend2      : cnt[rd_idN] != 0
// Every nonzero counter not being set decrements by one per cycle; a set
// on the same cycle as a decrement wins.
module reg_scoreboard
  import decode_fwd_scoreboard_pkg::*;
#(
  parameter int unsigned NREG  = NREG_DEF,
  parameter int unsigned LAT_W = LAT_W_DEF,
  localparam int unsigned IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_id,
  input  logic [LAT_W-1:0] set_lat,
  input  logic [IDX_W-1:0] rd_id1,
  input  logic [IDX_W-1:0] rd_id2,
  output logic             pend1,
  output logic             pend2
);

  logic [LAT_W-1:0] cnt [NREG];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (r != 0 && set_en && set_id == IDX_W'(r))
          cnt[r] <= set_lat;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - LAT_W'(1);
      end
    end
  end

  always_comb begin
    pend1 = (cnt[rd_id1] != '0);
    pend2 = (cnt[rd_id2] != '0);
  end

endmodule

// File: rtl/decode_fwd_scoreboard.sv
// decode_fwd_scoreboard: decode-stage operand resolution and RAW hazard unit.
//   in_*            : decoded instruction (valid/ready handshake)
//   rd1/rd2         : register-file read data
//   fwd_valid/id/data : NUM_FWD forwarding buses, index 0 youngest / highest priority
//   flush           : squash the output slot
//   out_*           : registered output slot (valid/ready) with resolved operands
//   hazard          : in_valid and a source register still pending
//   stall_cycles    : saturating count of hazard cycles
module decode_fwd_scoreboard
  import decode_fwd_scoreboard_pkg::*;
#(
  parameter int unsigned NREG    = NREG_DEF,
  parameter int unsigned NUM_FWD = NUM_FWD_DEF,
  parameter int unsigned LAT_W   = LAT_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  localparam int unsigned IDX_W  = $clog2(NREG)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_re,
  input  logic [IDX_W-1:0]           in_ra1,
  input  logic [IDX_W-1:0]           in_ra2,
  input  logic [DATA_W-1:0]          rd1,
  input  logic [DATA_W-1:0]          rd2,
  input  logic                       in_wen,
  input  logic [IDX_W-1:0]           in_wid,
  input  logic [LAT_W-1:0]           in_lat,
  input  logic [NUM_FWD-1:0]         fwd_valid,
  input  logic [NUM_FWD*IDX_W-1:0]   fwd_id,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_valA,
  output logic [DATA_W-1:0]          out_valB,
  output logic                       out_wen,
  output logic [IDX_W-1:0]           out_wid,
  output logic [LAT_W-1:0]           out_lat,
  output logic                       hazard,
  output logic [31:0]                stall_cycles
);

  logic sb_set;
  logic pend1, pend2;
  logic busy1, busy2;
  logic fire;
  logic [DATA_W-1:0] val_a, val_b;

  // Counters are only armed when Execute actually takes the slot.
  assign sb_set = out_valid && out_ready && out_wen && (out_wid != '0);

  reg_scoreboard #(
    .NREG  (NREG),
    .LAT_W (LAT_W)
  ) u_sb (
    .clk     (clk),
    .resetn  (resetn),
    .set_en  (sb_set),
    .set_id  (out_wid),
    .set_lat (out_lat),
    .rd_id1  (in_ra1),
    .rd_id2  (in_ra2),
    .pend1   (pend1),
    .pend2   (pend2)
  );

  // The slot occupant has not armed its counter yet, so it is matched directly.
  always_comb begin
    busy1  = in_re[0] && (in_ra1 != '0) &&
             (pend1 || (out_valid && out_wen && out_wid == in_ra1));
    busy2  = in_re[1] && (in_ra2 != '0) &&
             (pend2 || (out_valid && out_wen && out_wid == in_ra2));
    hazard = in_valid && (busy1 || busy2);
    in_ready = !hazard && (!out_valid || out_ready) && !flush;
    fire   = in_valid && in_ready;
  end

  function automatic logic [DATA_W-1:0] resolve(input logic re,
                                                input logic [IDX_W-1:0] ra,
                                                input logic [DATA_W-1:0] rd);
    logic [DATA_W-1:0] v;
    logic hit;
    v   = rd;
    hit = 1'b0;
    if (!re || ra == '0) begin
      v = '0;
    end else begin
      for (int unsigned k = 0; k < NUM_FWD; k++) begin
        if (!hit && fwd_valid[k] && fwd_id[k*IDX_W +: IDX_W] == ra) begin
          v   = fwd_data[k*DATA_W +: DATA_W];
          hit = 1'b1;
        end
      end
    end
    return v;
  endfunction

  always_comb begin
    val_a = resolve(in_re[0], in_ra1, rd1);
    val_b = resolve(in_re[1], in_ra2, rd2);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_valA  <= '0;
      out_valB  <= '0;
      out_wen   <= 1'b0;
      out_wid   <= '0;
      out_lat   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_valA  <= val_a;
      out_valB  <= val_b;
      out_wen   <= in_wen;
      out_wid   <= in_wid;
      out_lat   <= in_lat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stall_cycles <= '0;
    else if (hazard && stall_cycles != '1)
      stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_decode_fwd_scoreboard.sv
// Bench for decode_fwd_scoreboard: directed scenarios followed by random
// traffic, all compared against a timestamp-based reference model.
module tb_decode_fwd_scoreboard;
  import decode_fwd_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready;
  logic [1:0]  in_re;
  logic [4:0]  in_ra1, in_ra2, in_wid, out_wid;
  logic [31:0] rd1, rd2, out_valA, out_valB, stall_cycles;
  logic        in_wen, out_wen, out_valid, out_ready, flush, hazard;
  logic [2:0]  in_lat, out_lat;
  logic [1:0]  fwd_valid;
  logic [9:0]  fwd_id;
  logic [63:0] fwd_data;

  decode_fwd_scoreboard #(
    .NREG(32), .NUM_FWD(2), .LAT_W(3), .DATA_W(32)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re),
    .in_ra1(in_ra1), .in_ra2(in_ra2), .rd1(rd1), .rd2(rd2),
    .in_wen(in_wen), .in_wid(in_wid), .in_lat(in_lat),
    .fwd_valid(fwd_valid), .fwd_id(fwd_id), .fwd_data(fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_valA(out_valA), .out_valB(out_valB), .out_wen(out_wen),
    .out_wid(out_wid), .out_lat(out_lat), .hazard(hazard),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a register is unavailable until the cycle stamp
  // recorded when its producer left the slot (accept cycle + 1 + latency).
  longint      cyc = 0;
  longint      avail [32];
  logic        m_valid, m_wen;
  logic [31:0] m_valA, m_valB, m_stall;
  logic [4:0]  m_wid;
  logic [2:0]  m_lat;
  logic        last_hz, last_rdy;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) avail[r] = 0;
    m_valid = 0; m_wen = 0; m_valA = 0; m_valB = 0;
    m_wid = 0; m_lat = 0; m_stall = 0;
  endtask

  function automatic bit m_busy(input logic re, input logic [4:0] ra);
    if (!re || ra == 0) return 0;
    return (cyc < avail[ra]) || (m_valid && m_wen && m_wid == ra);
  endfunction

  function automatic logic [31:0] m_operand(input logic re, input logic [4:0] ra,
                                            input logic [31:0] rd);
    if (!re || ra == 0) return 32'h0;
    for (int k = 0; k < 2; k++)
      if (fwd_valid[k] && fwd_id[k*5 +: 5] == ra) return fwd_data[k*32 +: 32];
    return rd;
  endfunction

  // Inputs are driven at posedge+1; this samples at posedge+2, then
  // advances the model and the clock to the next posedge+1.
  task automatic step();
    bit exp_h, exp_r;
    logic [31:0] ea, eb;
    #1;
    if (!resetn) model_reset();
    exp_h = in_valid && (m_busy(in_re[0], in_ra1) || m_busy(in_re[1], in_ra2));
    exp_r = !exp_h && (!m_valid || out_ready) && !flush;
    ea = m_operand(in_re[0], in_ra1, rd1);
    eb = m_operand(in_re[1], in_ra2, rd2);
    check_val("hazard",    {31'b0, hazard},    {31'b0, exp_h});
    check_val("in_ready",  {31'b0, in_ready},  {31'b0, exp_r});
    check_val("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check_val("out_valA",  out_valA, m_valA);
    check_val("out_valB",  out_valB, m_valB);
    check_val("out_wen",   {31'b0, out_wen},   {31'b0, m_wen});
    check_val("out_wid",   {27'b0, out_wid},   {27'b0, m_wid});
    check_val("out_lat",   {29'b0, out_lat},   {29'b0, m_lat});
    check_val("stall_cnt", stall_cycles, m_stall);
    last_hz  = hazard;
    last_rdy = in_ready;
    if (resetn) begin
      if (m_valid && out_ready && m_wen && m_wid != 0)
        avail[m_wid] = cyc + 1 + longint'(m_lat);
      if (exp_h && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (flush) m_valid = 0;
      else if (in_valid && exp_r) begin
        m_valid = 1; m_valA = ea; m_valB = eb;
        m_wen = in_wen; m_wid = in_wid; m_lat = in_lat;
      end else if (out_ready) m_valid = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_re = 0; in_ra1 = 0; in_ra2 = 0; rd1 = 0; rd2 = 0;
    in_wen = 0; in_wid = 0; in_lat = 0; fwd_valid = 0; fwd_id = 0;
    fwd_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [1:0] re, input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic wen, input logic [4:0] wid, input logic [2:0] lat);
    in_valid = 1; in_re = re; in_ra1 = ra1; in_ra2 = ra2;
    in_wen = wen; in_wid = wid; in_lat = lat;
  endtask

  // Steps until the current instruction is no longer stalled; returns stall count.
  task automatic issue_wait(output int n);
    n = 0;
    do begin
      step();
      if (last_hz) n++;
    end while (last_hz && n < 20);
  endtask

  task automatic rand_inputs();
    in_valid = ($urandom_range(0, 9) < 8);
    in_re    = 2'($urandom);
    in_ra1   = 5'($urandom_range(0, 7));
    in_ra2   = 5'($urandom_range(0, 7));
    rd1      = $urandom;
    rd2      = $urandom;
    in_wen   = ($urandom_range(0, 3) != 0);
    in_wid   = 5'($urandom_range(0, 7));
    in_lat   = 3'($urandom);
    fwd_valid = 2'($urandom);
    for (int k = 0; k < 2; k++) begin
      fwd_id[k*5 +: 5]    = 5'($urandom_range(0, 7));
      fwd_data[k*32 +: 32] = $urandom;
    end
    flush     = ($urandom_range(0, 15) == 0);
    out_ready = ($urandom_range(0, 3) != 0);
    resetn    = ($urandom_range(0, 299) != 0);
  endtask

  initial begin
    int n;
    logic [31:0] s0;
    model_reset();
    idle();
    resetn = 0;
    @(posedge clk); #1;

    // Reset with an instruction presented
    issue(2'b01, 5'd1, 5'd0, 1, 5'd2, LAT_ALU);
    step(); step();
    check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("rst_stall", stall_cycles, 32'd0);
    idle();
    resetn = 1;
    step();
    check_val("rst_in_ready", {31'b0, last_rdy}, 32'd1);

    // ALU chain through r5
    issue(2'b00, 5'd0, 5'd0, 1, 5'd5, LAT_ALU);
    step();
    issue(2'b01, 5'd5, 5'd0, 0, 5'd0, 3'd0);
    fwd_valid = 2'b01; fwd_id[4:0] = 5'd5; fwd_data[31:0] = 32'h1234; rd1 = 32'hDEAD;
    issue_wait(n);
    check_val("alu_stalls", n, 32'd2);
    check_val("alu_fwd", out_valA, 32'h1234);
    idle();

    // Load-use with latency 2
    s0 = stall_cycles;
    issue(2'b00, 5'd0, 5'd0, 1, 5'd8, LAT_LOAD);
    step();
    issue(2'b01, 5'd8, 5'd0, 0, 5'd0, 3'd0);
    fwd_valid = 2'b01; fwd_id[4:0] = 5'd8; fwd_data[31:0] = 32'hCAFE0008;
    issue_wait(n);
    check_val("load_stalls", n, 32'd3);
    check_val("load_stall_cnt", stall_cycles - s0, 32'd3);
    check_val("load_fwd", out_valA, 32'hCAFE0008);
    idle();

    // Forwarding priority and r0
    issue(2'b11, 5'd3, 5'd0, 0, 5'd0, 3'd0);
    fwd_valid = 2'b11; fwd_id = {5'd3, 5'd3}; fwd_data = {32'hBBBB, 32'hAAAA};
    rd1 = 32'hCCCC; rd2 = 32'h7777;
    step();
    check_val("prio_fwd0", out_valA, 32'hAAAA);
    check_val("prio_r0", out_valB, 32'h0);
    fwd_id = {5'd3, 5'd4};
    step();
    check_val("prio_fwd1", out_valA, 32'hBBBB);
    issue(2'b01, 5'd0, 5'd0, 0, 5'd0, 3'd0);
    fwd_id = {5'd0, 5'd0};
    step();
    check_val("ra0_zero", out_valA, 32'h0);
    idle();
    step();

    // Flush of a pending long-latency producer
    issue(2'b00, 5'd0, 5'd0, 1, 5'd9, 3'd4);
    out_ready = 0;
    step();
    idle(); out_ready = 0; flush = 1;
    step();
    check_val("flush_valid", {31'b0, out_valid}, 32'd0);
    idle();
    issue(2'b01, 5'd9, 5'd0, 0, 5'd0, 3'd0);
    rd1 = 32'h99;
    step();
    check_val("flush_nostall", {31'b0, last_hz}, 32'd0);
    check_val("flush_issue", {31'b0, out_valid}, 32'd1);
    idle();

    // Backpressure while an earlier producer drains
    issue(2'b00, 5'd0, 5'd0, 1, 5'd10, 3'd3);
    step();
    issue(2'b00, 5'd0, 5'd0, 1, 5'd11, LAT_ALU);
    step();
    issue(2'b01, 5'd10, 5'd0, 0, 5'd0, 3'd0);
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("bp_in_ready", {31'b0, last_rdy}, 32'd0);
      check_val("bp_wid", {27'b0, out_wid}, 32'd11);
    end
    check_val("bp_cnt_drained", {31'b0, last_hz}, 32'd0);
    idle();
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
